// File: rtl/pkg_write_controller_if.sv
// Packet word stream carried into the write controller.
// The source drives words and framing; the controller answers with ready.
interface pkg_write_controller_if #(
    parameter int DATA_WIDTH = 8
) ();
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_sop;
    logic                  in_eop;

    modport master (
        output in_valid,
        output in_data,
        output in_sop,
        output in_eop,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_sop,
        input  in_eop,
        output in_ready
    );
endinterface

// File: rtl/pkg_write_controller.sv
// Writes a packet word stream into paged data RAM, chaining pages
// through a link table and reporting head/tail/length per packet.
module pkg_write_controller #(
    parameter int ADDR_WIDTH        = 6,
    parameter int ADDR_PAGE_NUM_LOG = 4,
    parameter int DATA_WIDTH        = 8,
    parameter int LEN_WIDTH         = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    pkg_write_controller_if.slave        in_if,
    output logic                         empty_table_read_req,
    input  logic [ADDR_PAGE_NUM_LOG-1:0] empty_table_read_addr,
    input  logic                         empty_table_empty,
    output logic                         ram_write_req,
    output logic [ADDR_WIDTH-1:0]        ram_write_addr,
    output logic [DATA_WIDTH-1:0]        ram_write_data,
    output logic                         link_write_req,
    output logic [ADDR_PAGE_NUM_LOG-1:0] link_write_addr,
    output logic [ADDR_PAGE_NUM_LOG-1:0] link_write_data,
    output logic                         pkg_done,
    output logic [ADDR_PAGE_NUM_LOG-1:0] pkg_head_addr,
    output logic [ADDR_PAGE_NUM_LOG-1:0] pkg_tail_addr,
    output logic [LEN_WIDTH-1:0]         pkg_length,
    output logic                         protocol_err
);
    localparam int OFF_W = ADDR_WIDTH - ADDR_PAGE_NUM_LOG;

    typedef enum logic {IDLE, BODY} state_t;

    state_t                       st, st_nx;
    logic                         run;
    logic [ADDR_PAGE_NUM_LOG-1:0] spare, cur_page, head, page;
    logic                         spare_valid;
    logic [1:0]                   gap;
    logic [OFF_W-1:0]             offset;
    logic [LEN_WIDTH-1:0]         len, len_nx;
    logic                         ready, acc, fetch, take, wr, err_nx;

    // run keeps combinational outputs low while reset is held
    always_comb begin
        st_nx  = st;
        ready  = 1'b0;
        take   = 1'b0;
        wr     = 1'b0;
        err_nx = 1'b0;
        page   = cur_page;
        len_nx = len;
        fetch  = run & ~spare_valid & ~empty_table_empty & (gap == 2'd0);
        unique case (st)
            IDLE: ready = spare_valid | ~in_if.in_sop;
            BODY: ready = (offset != '0) | spare_valid;
        endcase
        ready = ready & run;
        acc   = in_if.in_valid & ready;
        unique case (st)
            IDLE: begin
                if (acc && in_if.in_sop) begin
                    take   = 1'b1;
                    wr     = 1'b1;
                    page   = spare;
                    len_nx = LEN_WIDTH'(1);
                    st_nx  = in_if.in_eop ? IDLE : BODY;
                end else if (acc) begin
                    err_nx = 1'b1;
                end
            end
            BODY: begin
                if (acc) begin
                    wr = 1'b1;
                    if (offset == '0) begin
                        take = 1'b1;
                        page = spare;
                    end
                    len_nx = (&len) ? len : len + 1'b1;
                    if (in_if.in_eop) st_nx = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st              <= IDLE;
            run             <= 1'b0;
            spare           <= '0;
            spare_valid     <= 1'b0;
            gap             <= '0;
            cur_page        <= '0;
            head            <= '0;
            offset          <= '0;
            len             <= '0;
            ram_write_req   <= 1'b0;
            ram_write_addr  <= '0;
            ram_write_data  <= '0;
            link_write_req  <= 1'b0;
            link_write_addr <= '0;
            link_write_data <= '0;
            pkg_done        <= 1'b0;
            pkg_head_addr   <= '0;
            pkg_tail_addr   <= '0;
            pkg_length      <= '0;
            protocol_err    <= 1'b0;
        end else begin
            st             <= st_nx;
            run            <= 1'b1;
            ram_write_req  <= wr;
            link_write_req <= take & (st == BODY);
            pkg_done       <= wr & in_if.in_eop;
            protocol_err   <= err_nx;
            if (fetch) begin
                gap         <= 2'd2;
                spare       <= empty_table_read_addr;
                spare_valid <= 1'b1;
            end else begin
                if (gap != 2'd0) gap <= gap - 2'd1;
                if (take) spare_valid <= 1'b0;
            end
            if (wr) begin
                ram_write_addr <= {page, offset};
                ram_write_data <= in_if.in_data;
                cur_page       <= page;
                len            <= len_nx;
                offset         <= in_if.in_eop ? '0 : offset + 1'b1;
                if (st == IDLE) head <= spare;
            end
            if (take && st == BODY) begin
                link_write_addr <= cur_page;
                link_write_data <= spare;
            end
            if (wr && in_if.in_eop) begin
                pkg_head_addr <= (st == IDLE) ? spare : head;
                pkg_tail_addr <= page;
                pkg_length    <= len_nx;
            end
        end
    end

    assign in_if.in_ready       = ready;
    assign empty_table_read_req = fetch;
endmodule

// File: doc/pkg_write_controller.md
PKG_WRITE_CONTROLLER -- requirements
Module: pkg_write_controller

Interface
REQ-001 Parameters: ADDR_WIDTH, default 6, word address width of the data RAM.
REQ-002 Parameters: ADDR_PAGE_NUM_LOG, default 4, page index width; page size PAGE_WORDS = 2^(ADDR_WIDTH-ADDR_PAGE_NUM_LOG).
REQ-003 Parameters: DATA_WIDTH, default 8, packet word width; LEN_WIDTH, default 16, packet length counter width.
REQ-004 Ports: clk  in  1  the single clock; rst_n  in  1  reset, asynchronous, active-low.
REQ-005 Ports: in_valid  in  1; in_ready  out  1; in_data  in  DATA_WIDTH; in_sop  in  1; in_eop  in  1  (packet word stream, transfer when in_valid&in_ready).
REQ-006 Ports: empty_table_read_req  out  1  pop request; empty_table_read_addr  in  ADDR_PAGE_NUM_LOG  current free page; empty_table_empty  in  1  free list empty.
REQ-007 Ports: ram_write_req  out  1; ram_write_addr  out  ADDR_WIDTH; ram_write_data  out  DATA_WIDTH  (data RAM write).
REQ-008 Ports: link_write_req  out  1; link_write_addr  out  ADDR_PAGE_NUM_LOG; link_write_data  out  ADDR_PAGE_NUM_LOG  (next-page pointer write).
REQ-009 Ports: pkg_done  out  1; pkg_head_addr, pkg_tail_addr  out  ADDR_PAGE_NUM_LOG; pkg_length  out  LEN_WIDTH; protocol_err  out  1.

Function
REQ-010 The block SHALL hold one prefetched free page in a spare register with flag spare_valid.
REQ-011 When spare_valid=0, empty_table_empty=0 and gap counter=0, the block SHALL assert empty_table_read_req for exactly one cycle and capture empty_table_read_addr in that same cycle, setting spare_valid next cycle.
REQ-012 After any read_req the block SHALL keep read_req low for at least two following cycles (gap counter 2->0).
REQ-013 FSM states: IDLE (no packet open), BODY (packet open); reset state IDLE.
REQ-014 in_ready SHALL be combinational: IDLE: spare_valid | ~in_sop; BODY: (offset!=0) | spare_valid.
REQ-015 IDLE, accepted word with in_sop=0: word discarded, no writes, protocol_err pulses one cycle.
REQ-016 Accepted word with offset=0 SHALL consume spare as cur_page (spare_valid cleared that cycle; refill per REQ-011 no earlier than next cycle).
REQ-017 IDLE, accepted sop word: head<=spare, length<=1, state BODY (or stay IDLE if in_eop also set, single-word packet).
REQ-018 BODY, accepted word starting a new page (offset=0): link_write_req with addr=prev cur_page, data=new page, one cycle after acceptance.
REQ-019 Every accepted non-discarded word SHALL produce ram_write_req one cycle later with addr={cur_page,offset} and the word as data.
REQ-020 offset SHALL increment per accepted word, wrap PAGE_WORDS-1 -> 0, and reset to 0 on eop (tail page remainder unused).
REQ-021 in_sop during BODY SHALL be ignored (word treated as body word).
REQ-022 Accepted eop word: pkg_done pulses one cycle later, coincident with its ram write, carrying head, tail=its page, length=word count; state IDLE.
REQ-023 pkg_length SHALL saturate at 2^LEN_WIDTH-1.
REQ-024 empty_table_empty=1 at a page boundary SHALL stall (in_ready=0) with no data loss; no timeout.

Reset
REQ-025 rst_n low SHALL asynchronously clear FSM to IDLE, spare_valid, offset, gap counter, and drive every output (in_ready, all req/valid pulses, addresses, data, length, protocol_err) to 0.
REQ-026 Reset mid-packet SHALL abandon the packet with no pkg_done; consumed pages are not returned.

Verification (ADDR_WIDTH=6, PAGE_LOG=4, PAGE_WORDS=4)
REQ-027 Release reset, empty=0, read_addr=3 -> read_req one cycle, spare=3, no further read_req for 2 cycles.
REQ-028 Free pages 3 then 7; 6-word packet D0..D5 -> ram writes to 12,13,14,15,28,29; link write 3->7; pkg_done head=3 tail=7 length=6.
REQ-029 Single word with sop&eop, spare=5 -> ram write addr 20; pkg_done head=5 tail=5 length=1; no link write.
REQ-030 Word without sop in IDLE -> in_ready=1, no ram write, protocol_err one-cycle pulse.
REQ-031 Empty=1 at word 5 of packet -> in_ready=0 until empty=0 and spare captured; then writes resume at new page, data order intact.
REQ-032 Assert rst_n low mid-packet -> all outputs 0 immediately; subsequent packet starts from fresh prefetch with correct head.
